// File: rtl/wb_regfile.sv
// Writeback mux, 32-entry register file (x0 hardwired zero) with write-through read bypass, and retire counter.
// Reads and wb_data are combinational (zero latency); writes and counter update on CLK; no backpressure.
module wb_regfile #(
    parameter int size  = 32,
    parameter int CNT_W = 64
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [size-1:0]  salida_ram_WB,
    input  logic [size-1:0]  alu_resultado_WB,
    input  logic [4:0]       wrin_WB,
    input  logic             RegWrite_WB,
    input  logic             MemtoReg_WB,
    input  logic             retire_WB,
    input  logic             instret_clr,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    output logic [size-1:0]  rs1_data,
    output logic [size-1:0]  rs2_data,
    output logic [size-1:0]  wb_data,
    output logic [CNT_W-1:0] instret
);

    // x0 has no storage; entries 1..31 only.
    logic [size-1:0] regs [1:31];

    assign wb_data = MemtoReg_WB ? salida_ram_WB : alu_resultado_WB;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (RegWrite_WB && (wrin_WB != 5'd0)) begin
            regs[wrin_WB] <= wb_data;
        end
    end

    // The x0 check comes first so a bypass match on index 0 still reads zero.
    function automatic logic [size-1:0] read_port(input logic [4:0] addr);
        logic [size-1:0] val;
        val = '0;
        if (addr != 5'd0) begin
            if (RegWrite_WB && (wrin_WB == addr)) begin
                val = wb_data;
            end else begin
                val = regs[addr];
            end
        end
        return val;
    endfunction

    always_comb begin
        rs1_data = read_port(rs1_addr);
        rs2_data = read_port(rs2_addr);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            instret <= '0;
        end else if (instret_clr) begin
            instret <= '0;
        end else if (retire_WB) begin
            instret <= instret + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: stimulus queues expectations, a negedge monitor pops and compares them.
module tb_wb_regfile;

    logic        clk;
    logic        reset_n;
    logic [31:0] ram, alu;
    logic [4:0]  wrin, rs1a, rs2a;
    logic        regwrite, memtoreg, retire, clr;
    logic [31:0] rs1d, rs2d, wbd, rs1d_s, rs2d_s, wbd_s;
    logic [63:0] ir;
    logic [3:0]  ir4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [4:0]  mask;   // bit0 rs1, bit1 rs2, bit2 wb, bit3 instret, bit4 small instret
        logic [31:0] rs1, rs2, wb;
        logic [63:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t exp_q[$];

    wb_regfile #(.size(32), .CNT_W(64)) dut (
        .CLK(clk), .RESET_N(reset_n),
        .salida_ram_WB(ram), .alu_resultado_WB(alu), .wrin_WB(wrin),
        .RegWrite_WB(regwrite), .MemtoReg_WB(memtoreg), .retire_WB(retire),
        .instret_clr(clr), .rs1_addr(rs1a), .rs2_addr(rs2a),
        .rs1_data(rs1d), .rs2_data(rs2d), .wb_data(wbd), .instret(ir)
    );

    // Narrow-counter instance sharing the stimulus, used to reach the wrap point.
    wb_regfile #(.size(32), .CNT_W(4)) dut_small (
        .CLK(clk), .RESET_N(reset_n),
        .salida_ram_WB(ram), .alu_resultado_WB(alu), .wrin_WB(wrin),
        .RegWrite_WB(regwrite), .MemtoReg_WB(memtoreg), .retire_WB(retire),
        .instret_clr(clr), .rs1_addr(rs1a), .rs2_addr(rs2a),
        .rs1_data(rs1d_s), .rs2_data(rs2d_s), .wb_data(wbd_s), .instret(ir4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic rw, input logic mtr, input logic [4:0] wr,
                         input logic [31:0] alu_v, input logic [31:0] ram_v,
                         input logic ret, input logic cl,
                         input logic [4:0] a1, input logic [4:0] a2);
        @(posedge clk);
        #1;
        regwrite = rw; memtoreg = mtr; wrin = wr; alu = alu_v; ram = ram_v;
        retire = ret; clr = cl; rs1a = a1; rs2a = a2;
    endtask

    task automatic expect_out(input string name, input logic [4:0] mask,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input logic [31:0] ew, input logic [63:0] ec,
                              input logic [3:0] ec4);
        exp_t e;
        e.name = name; e.mask = mask; e.rs1 = e1; e.rs2 = e2; e.wb = ew;
        e.cnt = ec; e.cnt4 = ec4;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.mask[0]) begin
                checks++;
                if (rs1d !== e.rs1) begin
                    errors++;
                    $display("FAIL %s rs1_data: got %h expected %h", e.name, rs1d, e.rs1);
                end
            end
            if (e.mask[1]) begin
                checks++;
                if (rs2d !== e.rs2) begin
                    errors++;
                    $display("FAIL %s rs2_data: got %h expected %h", e.name, rs2d, e.rs2);
                end
            end
            if (e.mask[2]) begin
                checks++;
                if (wbd !== e.wb) begin
                    errors++;
                    $display("FAIL %s wb_data: got %h expected %h", e.name, wbd, e.wb);
                end
            end
            if (e.mask[3]) begin
                checks++;
                if (ir !== e.cnt) begin
                    errors++;
                    $display("FAIL %s instret: got %0d expected %0d", e.name, ir, e.cnt);
                end
            end
            if (e.mask[4]) begin
                checks++;
                if (ir4 !== e.cnt4) begin
                    errors++;
                    $display("FAIL %s instret4: got %0d expected %0d", e.name, ir4, e.cnt4);
                end
            end
        end
    end

    localparam logic [4:0] RD  = 5'b00011;
    localparam logic [4:0] RDW = 5'b00111;
    localparam logic [4:0] CN  = 5'b11000;
    localparam logic [4:0] ALL = 5'b11111;

    initial begin
        reset_n = 1'b0;
        regwrite = 0; memtoreg = 0; wrin = 0; alu = 0; ram = 0;
        retire = 0; clr = 0; rs1a = 0; rs2a = 0;

        // Reset held: reads and counters are zero.
        drive(0, 0, 0, 0, 0, 0, 0, 5, 31);
        expect_out("rst_hold", ALL, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 5, 31);
        reset_n = 1'b1;
        expect_out("rst_release", ALL, 0, 0, 0, 0, 0);

        // ALU and load writes, with bypass visible in the write cycle.
        drive(1, 0, 3, 32'h0000_1234, 32'h0, 0, 0, 3, 4);
        expect_out("wr_x3_byp", RDW, 32'h0000_1234, 0, 32'h0000_1234, 0, 0);
        drive(1, 1, 4, 32'h1111_1111, 32'hDEAD_BEEF, 0, 0, 3, 4);
        expect_out("wr_x4_byp", RDW, 32'h0000_1234, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 3, 4);
        expect_out("rd_x3_x4", RDW, 32'h0000_1234, 32'hDEAD_BEEF, 0, 0, 0);

        // x0 protection.
        drive(1, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 3);
        expect_out("x0_same", RDW, 0, 32'h0000_1234, 32'hFFFF_FFFF, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("x0_after", RDW, 0, 0, 0, 0, 0);

        // Bypass and RegWrite gating.
        drive(1, 0, 7, 32'h5, 0, 0, 0, 7, 0);
        expect_out("x7_init", RDW, 32'h5, 0, 32'h5, 0, 0);
        drive(1, 0, 7, 32'h9, 0, 0, 0, 7, 7);
        expect_out("x7_byp", RDW, 32'h9, 32'h9, 32'h9, 0, 0);
        drive(0, 0, 7, 32'hA, 0, 0, 0, 7, 7);
        expect_out("x7_nowr", RDW, 32'h9, 32'h9, 32'hA, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 7, 7);
        expect_out("x7_hold", RD, 32'h9, 32'h9, 0, 0, 0);
        drive(1, 0, 8, 32'h88, 0, 0, 0, 8, 7);
        expect_out("x8_byp_x7", RDW, 32'h88, 32'h9, 32'h88, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 8, 3);
        expect_out("x8_x3", RD, 32'h88, 32'h0000_1234, 0, 0, 0);

        // Retire counter: ten retires, clear beats retire, then wrap of the narrow counter.
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
            expect_out("cnt_up", CN, 0, 0, 0, 64'(i), 4'(i));
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("cnt_10", CN, 0, 0, 0, 10, 10);
        drive(0, 0, 0, 0, 0, 1, 1, 0, 0);
        expect_out("cnt_pre_clr", CN, 0, 0, 0, 10, 10);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("cnt_clr_wins", CN, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
            expect_out("cnt_run", CN, 0, 0, 0, 64'(i), 4'(i));
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("cnt_wrap", CN, 0, 0, 0, 16, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        expect_out("cnt_pre_clr2", CN, 0, 0, 0, 16, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("cnt_clr2", CN, 0, 0, 0, 0, 0);

        // Reset mid-operation.
        drive(1, 0, 10, 32'h77, 0, 0, 0, 10, 11);
        expect_out("x10_wr", RDW, 32'h77, 0, 32'h77, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0, 10, 11);
            expect_out("pre_rst_cnt", CN | 5'b00011, 32'h77, 0, 0, 64'(i), 4'(i));
        end
        drive(0, 0, 0, 0, 0, 0, 0, 10, 11);
        expect_out("pre_rst", CN | RD, 32'h77, 0, 0, 3, 3);
        drive(1, 1, 11, 32'h0, 32'hCAFE_0011, 1, 0, 10, 11);
        reset_n = 1'b0;
        expect_out("rst_mid", 5'b11101, 0, 0, 32'hCAFE_0011, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 10, 11);
        reset_n = 1'b1;
        expect_out("post_rst_x11", CN | RD, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 3, 4);
        expect_out("post_rst_x3x4", RD, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback stage and architectural register file of the 5-stage pipeline.
- Consumes the MEM/WB pipeline register outputs, selects the writeback value (ALU result or loaded RAM data) and commits it to a 32-entry register file.
- Serves two combinational read ports to the decode stage, with same-cycle write-through bypass.
- Holds the retired-instruction counter.

Parameters:
- size, 32, data width of registers and datapaths
- CNT_W, 64, width of retired-instruction counter

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RESET_N  in  1  asynchronous active-low reset
- salida_ram_WB  in  size  load data from MEM/WB register
- alu_resultado_WB  in  size  ALU result from MEM/WB register
- wrin_WB  in  5  destination register index
- RegWrite_WB  in  1  register write enable
- MemtoReg_WB  in  1  1 = write load data, 0 = write ALU result
- retire_WB  in  1  instruction in WB is valid/retiring (0 for bubbles)
- instret_clr  in  1  synchronous clear of retire counter
- rs1_addr  in  5  read port 1 index
- rs2_addr  in  5  read port 2 index
- rs1_data  out  size  read port 1 data
- rs2_data  out  size  read port 2 data
- wb_data  out  size  selected writeback value (to forwarding unit)
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset: RESET_N asynchronous, active-low; clock CLK. While RESET_N=0, all 32 registers = 0 and instret = 0. Read ports therefore return 0 during and after reset until written.
- Writeback mux (combinational): wb_data = MemtoReg_WB ? salida_ram_WB : alu_resultado_WB. It is driven regardless of RegWrite_WB.
- Write: at rising CLK, if RegWrite_WB=1 and wrin_WB!=0, then regs[wrin_WB] <= wb_data. Only one write port; no other register changes.
- x0: register 0 is hardwired zero. Writes to index 0 are discarded, and reads of index 0 always return 0, including when bypass conditions match.
- Read (combinational, zero latency): rsN_data =
  - 0 if rsN_addr==0;
  - otherwise wb_data if RegWrite_WB=1 and wrin_WB==rsN_addr (write-through bypass: decode sees the value being written this cycle);
  - otherwise regs[rsN_addr].
- Both ports are independent; rs1_addr==rs2_addr is legal and both return identical data.
- Retire counter: at rising CLK, priority is instret_clr > retire_WB.
  - instret_clr=1: instret <= 0, even if retire_WB=1.
  - Else retire_WB=1: instret <= instret+1, with modulo 2^CNT_W wrap (all ones -> 0, no flag).
  - Else hold.
- retire_WB is independent of RegWrite_WB. Stores and branches retire without writing.
- Reset mid-operation: asserting RESET_N=0 at any point clears all registers and the counter immediately, without waiting for a clock edge. A write scheduled for the next edge is lost.
- No X propagation: all outputs are defined from reset onward.

Test Plan:
1. Reset then read: RESET_N=0 for 2 cycles, release, rs1_addr=5, rs2_addr=31 -> rs1_data=0, rs2_data=0, instret=0.
2. ALU and load writes: cycle 1 writes x3 with RegWrite=1, MemtoReg=0, alu=0x0000_1234. Cycle 2 writes x4 with MemtoReg=1, ram=0xDEAD_BEEF, alu=0x1111_1111. Then read rs1=3, rs2=4 -> 0x0000_1234, 0xDEAD_BEEF.
3. x0 protection: RegWrite=1, wrin=0, alu=0xFFFF_FFFF, rs1_addr=0 in the same cycle and after -> rs1_data=0 both times. wb_data=0xFFFF_FFFF.
4. Bypass and RegWrite gating:
   - x7 holds 0x5; drive RegWrite=1, wrin=7, alu=0x9, rs1_addr=rs2_addr=7 -> both read 0x9 in that cycle and after the edge.
   - Repeat with RegWrite=0, alu=0xA -> reads stay 0x9.
5. Counter: retire_WB=1 for 10 cycles with RegWrite=0 -> instret=10. Assert instret_clr=1 and retire_WB=1 together -> instret=0. Force the counter to 2^CNT_W-1 (CNT_W=4 variant: 15) plus one retire -> 0.
6. Reset mid-operation: after writing x10=0x77 and instret=3, pulse RESET_N low between clock edges -> rs data for x10 and instret read 0 immediately. A concurrent pending write to x11 is not committed.
